// File: rtl/seq_pkg.sv
// Shared types for the fetch-sequencing unit.
//   seq_cmd_t   : sequencing command carried on cmd
//   cond_t      : BR_COND condition code carried on cond
//   flag_t      : one registered comparison flag slot {eq, lt}
//   seq_state_t : RUN / HALTED
//   cond_true() : evaluates a condition code against a flag slot
package seq_pkg;

  typedef enum logic [2:0] {
    SEQ     = 3'd0,
    BR      = 3'd1,
    BR_COND = 3'd2,
    CALL    = 3'd3,
    RET     = 3'd4,
    HALT    = 3'd5
  } seq_cmd_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    NE = 2'd1,
    LT = 2'd2,
    GE = 2'd3
  } cond_t;

  typedef struct packed {
    logic eq;
    logic lt;
  } flag_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_t;

  function automatic logic cond_true(input cond_t c, input flag_t f);
    logic r;
    case (c)
      EQ:      r = f.eq;
      NE:      r = !f.eq;
      LT:      r = f.lt;
      default: r = !f.lt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Bus between the Control decoder (master) and pc_seq_unit (slave).
//   master drives : stall, cmd, cond, flag_sel, flag_we, equal, less, idx
//   slave drives  : prog_ctr, halted, stk_ovf, stk_udf, stk_cnt
interface pc_seq_unit_if #(
  parameter int unsigned D     = 10,
  parameter int unsigned NFLAG = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LUTW  = 5
) ();
  localparam int unsigned FW = $clog2(NFLAG);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            stall;
  logic [2:0]      cmd;
  logic [1:0]      cond;
  logic [FW-1:0]   flag_sel;
  logic            flag_we;
  logic            equal;
  logic            less;
  logic [LUTW-1:0] idx;
  logic [D-1:0]    prog_ctr;
  logic            halted;
  logic            stk_ovf;
  logic            stk_udf;
  logic [CW-1:0]   stk_cnt;

  modport master (
    output stall, cmd, cond, flag_sel, flag_we, equal, less, idx,
    input  prog_ctr, halted, stk_ovf, stk_udf, stk_cnt
  );

  modport slave (
    input  stall, cmd, cond, flag_sel, flag_we, equal, less, idx,
    output prog_ctr, halted, stk_ovf, stk_udf, stk_cnt
  );
endinterface

// File: rtl/pc_target_lut.sv
// Constant branch/call target table, read combinationally.
//   idx    : table index (instruction immediate)
//   target : D-bit destination PC; unlisted entries return 0
module pc_target_lut #(
  parameter int unsigned D    = 10,
  parameter int unsigned LUTW = 5
) (
  input  logic [LUTW-1:0] idx,
  output logic [D-1:0]    target
);

  always_comb begin
    target = '0;
    case (idx)
      LUTW'(1): target = D'(32'h010);
      LUTW'(2): target = D'(32'h3FF);
      LUTW'(3): target = D'(32'h040);
      LUTW'(4): target = D'(32'h100);
      LUTW'(5): target = D'(32'h120);
      LUTW'(6): target = D'(32'h140);
      LUTW'(7): target = D'(32'h160);
      LUTW'(8): target = D'(32'h180);
      default:  target = '0;
    endcase
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-sequencing unit: program counter, registered comparison flags,
// target LUT and a bounded call/return stack.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : pc_seq_unit_if.slave (command inputs, PC / status outputs)
// All outputs are registered; a command takes effect on the next edge.
module pc_seq_unit
  import seq_pkg::*;
#(
  parameter int unsigned D     = 10,
  parameter int unsigned NFLAG = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LUTW  = 5
) (
  input  logic          clk,
  input  logic          reset,
  pc_seq_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  seq_state_t    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  flag_t         flags_q [NFLAG];
  flag_t         flags_d [NFLAG];
  logic [D-1:0]  stk_q [DEPTH];
  logic [D-1:0]  stk_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [D-1:0]  pc_inc;
  logic [D-1:0]  target;
  logic [D-1:0]  stk_top;
  flag_t         cur_flag;
  seq_cmd_t      cmd_e;
  cond_t         cond_e;

  pc_target_lut #(.D(D), .LUTW(LUTW)) u_lut (
    .idx    (bus.idx),
    .target (target)
  );

  assign cmd_e  = seq_cmd_t'(bus.cmd);
  assign cond_e = cond_t'(bus.cond);
  assign pc_inc = pc_q + D'(1);

  always_comb begin
    cur_flag = flags_q[bus.flag_sel];
    stk_top  = '0;
    // Loop-compare rather than direct indexing: cnt is one bit wider than
    // the stack index, so this keeps the select width-exact.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) == cnt_q - CW'(1)) stk_top = stk_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (!bus.stall && state_q == ST_RUN) begin
      // Flag write lands on the edge; BR_COND below still sees flags_q.
      if (bus.flag_we) flags_d[bus.flag_sel] = '{eq: bus.equal, lt: bus.less};

      case (cmd_e)
        BR:      pc_d = target;
        BR_COND: pc_d = cond_true(cond_e, cur_flag) ? target : pc_inc;
        CALL: begin
          if (cnt_q == CW'(DEPTH)) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (CW'(i) == cnt_q) stk_d[i] = pc_inc;
            end
            cnt_d = cnt_q + CW'(1);
            pc_d  = target;
          end
        end
        RET: begin
          if (cnt_q == '0) begin
            pc_d  = pc_inc;
            udf_d = 1'b1;
          end else begin
            pc_d  = stk_top;
            cnt_d = cnt_q - CW'(1);
          end
        end
        HALT:    state_d = ST_HALTED;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int unsigned i = 0; i < NFLAG; i++) flags_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      flags_q <= flags_d;
      stk_q   <= stk_d;
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.halted   = (state_q == ST_HALTED);
  assign bus.stk_ovf  = ovf_q;
  assign bus.stk_udf  = udf_q;
  assign bus.stk_cnt  = cnt_q;

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised fetch-sequencing unit for the 9-bit-instruction core: it holds the program counter, a bank of registered ALU comparison flags, a branch-target lookup table and a bounded call/return stack. It generalises the separate PC and Branch blocks into one engine with configurable PC width, flag-slot count and call depth. It also adds conditional-branch polarity, subroutine call/return, stall and halt. It sits between the Control decoder and instr_ROM and drives `prog_ctr` directly.

## Interface
Parameters:
- `D`, 10, program counter width
- `NFLAG`, 4, number of flag slots, each holding {eq, lt}; power of 2, ≥2
- `DEPTH`, 4, return-stack entries; ≥1
- `LUTW`, 5, target-LUT index width; the LUT has 2^LUTW entries of D bits

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  freeze all state this cycle
- `cmd`  in  3  sequencing command (`seq_cmd_t`)
- `cond`  in  2  condition code for BR_COND (`cond_t`)
- `flag_sel`  in  $clog2(NFLAG)  flag slot read by BR_COND and written by flag_we
- `flag_we`  in  1  capture {equal, less} into slot `flag_sel`
- `equal`, `less`  in  1 each  ALU comparison results
- `idx`  in  LUTW  target-LUT index (instruction immediate)
- `prog_ctr`  out  D  current PC
- `halted`  out  1  sticky halt; serves as the core's done
- `stk_ovf`, `stk_udf`  out  1 each  sticky stack overflow / underflow
- `stk_cnt`  out  $clog2(DEPTH+1)  current stack occupancy

## Operation
Commands (`seq_cmd_t`): SEQ=0, BR=1, BR_COND=2, CALL=3, RET=4, HALT=5; codes 6–7 behave as SEQ.
- **SEQ**: PC ← PC+1, modulo 2^D.
- **BR**: PC ← lut[idx].
- **BR_COND**: the condition is evaluated on the registered flags of slot `flag_sel`. EQ=0 tests eq; NE=1 tests !eq; LT=2 tests lt; GE=3 tests !lt. Taken → PC ← lut[idx]; not taken → PC+1.
- **CALL**: push PC+1, then PC ← lut[idx]. If the stack is full (stk_cnt==DEPTH), there is no push, PC ← PC+1 and stk_ovf is set.
- **RET**: pop, and PC ← popped value. If the stack is empty, PC ← PC+1 and stk_udf is set.
- **HALT**: halted ← 1; PC holds.
- **Flags**: flag_we writes {equal, less} into slot flag_sel. This is independent of cmd and may coincide with any command.
- **Halted state**: once halted, PC, flags and stack hold until reset, regardless of cmd and flag_we.
- **Stall**: stall=1 holds every register, including flags, stack and sticky bits. Stall takes priority over everything except reset.
- **Two-state view**: RUN → HALTED on HALT when not stalled; HALTED → RUN only by reset.

## Timing
- **Reset values**: all outputs, flags, stack count and stack entries are 0 while reset is low. Reset takes effect immediately, including mid-call-chain.
- **Latency**: one cycle. The command applied in cycle n is reflected on `prog_ctr` after edge n+1. Outputs are purely registered.
- **Flag hazard**: BR_COND and flag_we to the same slot in one cycle → the branch uses the OLD flag value, and the new value is visible next cycle.
- **LUT**: combinational read of a constant table, so there is no extra latency.
- **Stack boundaries**: CALL at count DEPTH-1 succeeds and count becomes DEPTH. A RET following a rejected CALL pops the last successful push.
- **Wrap-around**: PC+1 at 2^D−1 yields 0; this applies to SEQ, to the CALL return address and to the fallback paths.
- **Sticky bits**: stk_ovf and stk_udf clear only on reset.

## Structure
- **Package `seq_pkg`**: holds `seq_cmd_t`, `cond_t`, and the flag struct {eq, lt}.
- **Sub-module `pc_target_lut`**: parametrised by D and LUTW, a combinational case table indexed by idx. Unlisted entries return 0.
- **Stack**: an array with a count pointer, inside pc_seq_unit.

## Test plan
- Release reset, then 5 SEQ → prog_ctr 0,1,2,3,4,5; no sticky bits set. Assert reset mid-run → prog_ctr=0 in the same cycle.
- Write flag slot 2 = {eq=1, lt=0}, then BR_COND EQ slot 2, idx 3 with lut[3]=0x40 → PC=0x40. The same with GE → taken; with LT → PC+1.
- In the same cycle, BR_COND NE on slot 1 (old eq=1) and flag_we slot 1 {0,0} → not taken. A repeat next cycle → taken.
- DEPTH=4: five CALLs from PC 0x10 → fifth not pushed, stk_ovf=1, stk_cnt=4. Four RETs return to each pushed PC+1 in LIFO order; a fifth RET → PC+1, stk_udf=1.
- D=10, PC=0x3FF, SEQ → 0x000; CALL at 0x3FF, then RET → 0x000.
- HALT at PC 7 → halted=1, PC stays 7 through later BR/CALL/flag_we. stall=1 during BR → no change. Reset → halted=0, PC=0.
